i2c_target: RTL and testbench

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_target.sv | 256 +++++++++++++++++++++++++
 tb/tb_i2c_target.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
`timescale 1ns/1ps
// i2c_target: 7-bit addressed I2C target with a 4 x 8-bit register file.
//
// Protocol: after START + address/W, the first data byte selects the
// register pointer; each later byte is written to reg[ptr] and the pointer
// advances. After START + address/R, reg[ptr] bytes are shifted out and the
// pointer advances after each byte until the master NACKs. The pointer wraps
// 3 -> 0 in both directions.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   scl        bus clock as read from the line
//   sda_in     bus data as read from the line
//   sda_oe     1 = pull SDA low, 0 = release (SDA is never driven high)
//   regs       register file, reg0 in [7:0] .. reg3 in [31:24]
//   ptr        current register pointer
//   busy       high from address match until STOP / abandoned transaction
//   wr_strobe  one-clk pulse when a data byte is written into regs
module i2c_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic [31:0] regs,
    output logic [1:0]  ptr,
    output logic        busy,
    output logic        wr_strobe
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_ACK1  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_ACK2  = 3'd4;
    localparam logic [2:0] S_SDATA = 3'd5;
    localparam logic [2:0] S_MACK  = 3'd6;

    // Synchronizers and one-cycle-delayed copies for edge detection.
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;

    logic [2:0]       state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             rw_q, rw_d;
    logic             ack_drv_q, ack_drv_d;   // ACK slot: 0 = waiting for first fall, 1 = driving
    logic             first_q, first_d;       // next DATA byte is the pointer byte
    logic [1:0]       ptr_q, ptr_d;
    logic [3:0][7:0]  regs_q, regs_d;
    logic             busy_q, busy_d;
    logic             sda_oe_q, sda_oe_d;
    logic             wr_strobe_q, wr_strobe_d;

    logic             scl_rise, scl_fall, start_det, stop_det;
    logic [7:0]       rx_byte;
    logic [7:0]       cur_reg;

    assign scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
    assign sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];

    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & ~sda_prev_q & sda_s;

    // Byte as it will look after the bit arriving on this rise is shifted in.
    assign rx_byte = {shift_q[6:0], sda_s};
    assign cur_reg = regs_q[ptr_q];

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        ack_drv_d   = ack_drv_q;
        first_d     = first_q;
        ptr_d       = ptr_q;
        regs_d      = regs_q;
        busy_d      = busy_q;
        sda_oe_d    = sda_oe_q;
        wr_strobe_d = 1'b0;

        // START/STOP outrank any SCL edge seen in the same cycle.
        if (stop_det) begin
            state_d   = S_IDLE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (start_det) begin
            state_d   = S_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            if (rx_byte[7:1] == DEV_ADDR) begin
                                state_d   = S_ACK1;
                                busy_d    = 1'b1;
                                rw_d      = rx_byte[0];
                                ack_drv_d = 1'b0;
                                first_d   = 1'b1;
                            end else begin
                                state_d = S_IDLE;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end

                S_ACK1: begin
                    if (scl_fall) begin
                        if (!ack_drv_q) begin
                            sda_oe_d  = 1'b1;
                            ack_drv_d = 1'b1;
                        end else if (rw_q) begin
                            // The fall that ends the ACK slot already presents
                            // the MSB of the first read byte.
                            state_d   = S_SDATA;
                            sda_oe_d  = ~cur_reg[7];
                            shift_d   = {cur_reg[6:0], 1'b0};
                            bit_cnt_d = 4'd1;
                        end else begin
                            state_d   = S_DATA;
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                        end
                    end
                end

                S_DATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            state_d   = S_ACK2;
                            ack_drv_d = 1'b0;
                            if (first_q) begin
                                ptr_d   = rx_byte[1:0];
                                first_d = 1'b0;
                            end else begin
                                regs_d[ptr_q] = rx_byte;
                                wr_strobe_d   = 1'b1;
                                ptr_d         = ptr_q + 2'd1;
                            end
                        end
                    end
                end

                S_ACK2: begin
                    if (scl_fall) begin
                        if (!ack_drv_q) begin
                            sda_oe_d  = 1'b1;
                            ack_drv_d = 1'b1;
                        end else begin
                            state_d   = S_DATA;
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                        end
                    end
                end

                S_SDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q != 4'd8) begin
                            sda_oe_d  = ~shift_q[7];
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end else begin
                            // All 8 bits out: release for the master's ACK slot.
                            sda_oe_d  = 1'b0;
                            ptr_d     = ptr_q + 2'd1;
                            bit_cnt_d = 4'd0;
                            state_d   = S_MACK;
                        end
                    end
                end

                S_MACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            state_d   = S_SDATA;
                            shift_d   = cur_reg;
                            bit_cnt_d = 4'd0;
                        end else begin
                            state_d  = S_IDLE;
                            sda_oe_d = 1'b0;
                            busy_d   = 1'b0;
                        end
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            state_q     <= S_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            rw_q        <= 1'b0;
            ack_drv_q   <= 1'b0;
            first_q     <= 1'b0;
            ptr_q       <= 2'd0;
            regs_q      <= '0;
            busy_q      <= 1'b0;
            sda_oe_q    <= 1'b0;
            wr_strobe_q <= 1'b0;
        end else begin
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            scl_prev_q  <= scl_s;
            sda_prev_q  <= sda_s;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            ack_drv_q   <= ack_drv_d;
            first_q     <= first_d;
            ptr_q       <= ptr_d;
            regs_q      <= regs_d;
            busy_q      <= busy_d;
            sda_oe_q    <= sda_oe_d;
            wr_strobe_q <= wr_strobe_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign regs      = regs_q;
    assign ptr       = ptr_q;
    assign busy      = busy_q;
    assign wr_strobe = wr_strobe_q;

endmodule

// File: tb/tb_i2c_target.sv
`timescale 1ns/1ps
// tb_i2c_target: bus-level master driving i2c_target with directed and
// random transactions. A register-file model predicts ACKs, read bytes and
// register writes; observations are queued and compared by separate monitors.
module tb_i2c_target;

    localparam int T = 40;  // quarter SCL period in ns

    logic        clk = 1'b0;
    logic        rst;
    logic        scl;
    logic        sda_m;
    logic        sda_line;
    logic        sda_oe;
    logic [31:0] regs;
    logic [1:0]  ptr;
    logic        busy;
    logic        wr_strobe;

    // Open-drain wired-AND of master and target.
    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target #(.DEV_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl      (scl),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .regs     (regs),
        .ptr      (ptr),
        .busy     (busy),
        .wr_strobe(wr_strobe)
    );

    int tests = 0;
    int fails = 0;

    typedef struct { int kind; logic [7:0] val; } ev_t;       // kind 0 = ACK bit, 1 = read byte
    typedef struct { logic [1:0] idx; logic [7:0] val; } wr_t;
    ev_t exp_q[$];
    ev_t act_q[$];
    wr_t exp_wr_q[$];

    // Reference model of the target's visible state.
    logic [7:0] m_regs [4];
    logic [1:0] m_ptr;
    logic [7:0] wbytes[$];

    logic oe_prev = 1'b0;
    int   oe_viol = 0;
    logic oe_seen = 1'b0;
    logic busy_seen = 1'b0;

    function automatic ev_t mk_ev(input int k, input logic [7:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        return e;
    endfunction

    function automatic wr_t mk_wr(input logic [1:0] i, input logic [7:0] v);
        wr_t w;
        w.idx = i;
        w.val = v;
        return w;
    endfunction

    function automatic logic [31:0] m_pack();
        return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Bus scoreboard monitor.
    initial begin : bus_mon
        ev_t a;
        ev_t e;
        forever begin
            @(negedge clk);
            while (act_q.size() > 0) begin
                a = act_q.pop_front();
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL bus_event: got kind %0d value %h, expected nothing", a.kind, a.val);
                end else begin
                    e = exp_q.pop_front();
                    if (a.kind != e.kind || a.val !== e.val) begin
                        fails++;
                        $display("FAIL bus_event: got kind %0d value %h, expected kind %0d value %h",
                                 a.kind, a.val, e.kind, e.val);
                    end
                end
            end
        end
    end

    // Register-write monitor.
    always @(negedge clk) begin : wr_mon
        wr_t w;
        if (rst === 1'b0 && wr_strobe === 1'b1) begin
            tests++;
            if (exp_wr_q.size() == 0) begin
                fails++;
                $display("FAIL wr_strobe: got pulse, expected none (regs=%h)", regs);
            end else begin
                w = exp_wr_q.pop_front();
                if (regs[int'(w.idx)*8 +: 8] !== w.val) begin
                    fails++;
                    $display("FAIL wr_data: reg%0d got %h, expected %h", w.idx, regs[int'(w.idx)*8 +: 8], w.val);
                end
            end
        end
    end

    // Bus-level observations: sda_oe must only move while SCL is low.
    always @(negedge clk) begin
        if (rst === 1'b0 && sda_oe !== oe_prev && scl === 1'b1) oe_viol++;
        oe_prev = sda_oe;
        if (sda_oe === 1'b1) oe_seen = 1'b1;
        if (busy === 1'b1) busy_seen = 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    task automatic bit_xfer(input logic b, output logic r);
        sda_m = b;
        #T scl = 1'b1;
        #T r = sda_line;
        #T scl = 1'b0;
        #T;
    endtask

    task automatic do_start();
        sda_m = 1'b1;
        #T scl = 1'b1;
        #T sda_m = 1'b0;
        #T scl = 1'b0;
        #T;
    endtask

    task automatic do_stop();
        sda_m = 1'b0;
        #T scl = 1'b1;
        #T sda_m = 1'b1;
        #(2*T);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_nack);
        logic r;
        exp_q.push_back(mk_ev(0, {7'b0, exp_nack}));
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
        bit_xfer(1'b1, r);
        act_q.push_back(mk_ev(0, {7'b0, r}));
    endtask

    task automatic recv_byte(input logic master_nack);
        logic [7:0] d;
        logic       r;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_xfer(1'b1, r);
            d = {d[6:0], r};
        end
        bit_xfer(master_nack, r);
        act_q.push_back(mk_ev(1, d));
    endtask

    // START, address+W, then wbytes; first byte is the pointer.
    task automatic txn_write(input logic [6:0] addr, input bit with_stop);
        logic hit;
        hit = (addr == 7'h50);
        do_start();
        send_byte({addr, 1'b0}, ~hit);
        check("busy_after_addr", {31'b0, busy}, {31'b0, hit});
        for (int i = 0; i < wbytes.size(); i++) begin
            if (hit) begin
                if (i == 0) begin
                    m_ptr = wbytes[0][1:0];
                end else begin
                    exp_wr_q.push_back(mk_wr(m_ptr, wbytes[i]));
                    m_regs[m_ptr] = wbytes[i];
                    m_ptr = m_ptr + 2'd1;
                end
            end
            send_byte(wbytes[i], ~hit);
        end
        if (with_stop) do_stop();
    endtask

    // (Repeated) START, address+R, read n bytes, NACK the last, STOP.
    task automatic txn_read(input int n);
        do_start();
        send_byte({7'h50, 1'b1}, 1'b0);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mk_ev(1, m_regs[m_ptr]));
            m_ptr = m_ptr + 2'd1;
            recv_byte(i == n - 1);
        end
        do_stop();
    endtask

    task automatic end_check(input string name);
        #(4*T);
        for (int k = 0; k < 100 && act_q.size() > 0; k++) @(negedge clk);
        #10;
        check("regs", regs, m_pack());
        check("ptr", {30'b0, ptr}, {30'b0, m_ptr});
        check("busy_idle", {31'b0, busy}, 32'd0);
        check("sda_oe_idle", {31'b0, sda_oe}, 32'd0);
        check("bus_queue_drained", exp_q.size(), 32'd0);
        check("wr_queue_drained", exp_wr_q.size(), 32'd0);
        $display("[TB] txn %s: regs=%h ptr=%0d (tests=%0d fails=%0d)", name, regs, ptr, tests, fails);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_ptr = 2'd0;
    endtask

    initial begin
        logic       r;
        logic [6:0] a;
        int         op;
        int         n;

        rst   = 1'b1;
        scl   = 1'b1;
        sda_m = 1'b1;
        model_reset();
        #100;
        check("rst_sda_oe", {31'b0, sda_oe}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_wr_strobe", {31'b0, wr_strobe}, 32'd0);
        check("rst_ptr", {30'b0, ptr}, 32'd0);
        check("rst_regs", regs, 32'd0);
        $display("[TB] txn reset: regs=%h ptr=%0d", regs, ptr);
        rst = 1'b0;
        #100;

        // Pointer 1, write 0x5A.
        wbytes = '{8'h01, 8'h5A};
        txn_write(7'h50, 1'b1);
        end_check("write_ptr1_5A");

        // Fill regs with 44332211, then read two bytes from pointer 2.
        wbytes = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        txn_write(7'h50, 1'b1);
        end_check("fill_regs");
        wbytes = '{8'h02};
        txn_write(7'h50, 1'b0);
        txn_read(2);
        end_check("read_wrap");

        // Wrong address: nothing may respond.
        oe_seen   = 1'b0;
        busy_seen = 1'b0;
        wbytes = '{8'h77};
        txn_write(7'h51, 1'b1);
        end_check("addr_mismatch");
        check("mismatch_oe_never", {31'b0, oe_seen}, 32'd0);
        check("mismatch_busy_never", {31'b0, busy_seen}, 32'd0);

        // Pointer 3 with wrap to 0.
        wbytes = '{8'h03, 8'hAA, 8'hBB};
        txn_write(7'h50, 1'b1);
        end_check("write_wrap");

        // Partial byte aborted by STOP.
        wbytes = '{8'h00};
        txn_write(7'h50, 1'b0);
        for (int i = 0; i < 4; i++) bit_xfer(1'b1, r);
        do_stop();
        end_check("partial_abort");

        // Reset while the address ACK is being driven.
        do_start();
        for (int i = 7; i >= 0; i--) bit_xfer(((8'hA0 >> i) & 8'h01) != 8'h00, r);
        sda_m = 1'b1;
        #T;
        check("ack_driving", {31'b0, sda_oe}, 32'd1);
        #3 rst = 1'b1;
        #1;
        check("rst_async_release", {31'b0, sda_oe}, 32'd0);
        #26 rst = 1'b0;
        model_reset();
        do_stop();
        wbytes = '{8'h00, 8'h12};
        txn_write(7'h50, 1'b1);
        end_check("after_reset_write");

        // Random transactions.
        for (int t = 0; t < 16; t++) begin
            op = $urandom_range(0, 3);
            if (op <= 1) begin
                wbytes = {};
                n = $urandom_range(0, 4);
                wbytes.push_back(8'($urandom));
                for (int i = 0; i < n; i++) wbytes.push_back(8'($urandom));
                txn_write(7'h50, 1'b1);
                end_check($sformatf("rand_write_%0d", t));
            end else if (op == 2) begin
                do begin
                    a = 7'($urandom);
                end while (a == 7'h50);
                wbytes = {};
                n = $urandom_range(1, 3);
                for (int i = 0; i < n; i++) wbytes.push_back(8'($urandom));
                oe_seen = 1'b0;
                txn_write(a, 1'b1);
                end_check($sformatf("rand_mismatch_%0d", t));
                check("rand_mismatch_oe", {31'b0, oe_seen}, 32'd0);
            end else begin
                wbytes = '{8'($urandom)};
                txn_write(7'h50, 1'b0);
                txn_read($urandom_range(1, 4));
                end_check($sformatf("rand_read_%0d", t));
            end
        end

        check("sda_oe_moved_with_scl_high", oe_viol, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
